// File: rtl/err_ctrl_pkg.sv
// rtl/err_ctrl_pkg.sv - shared constants and state encoding for the error-accumulation sequencer
//
// Holds the state enum, the number of weighted IR terms, the mux-select width
// and the settle-counter width used by err_compute_ctrl.
package err_ctrl_pkg;

  localparam int NUM_TERMS = 8;
  localparam int SEL_W     = 3;
  localparam int SETTLE_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    SETTLE = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4
  } err_ctrl_state_t;

endpackage

// File: rtl/err_compute_ctrl.sv
// rtl/err_compute_ctrl.sv - sequencer for the line-follower error-accumulation datapath
//
// On each IR_vld it clears the accumulator, optionally waits SETTLE_CYC cycles,
// then steps the 8-way mux select through all weighted terms (even selects are
// right sensors and add, odd selects are left sensors and subtract) and finally
// pulses err_vld for the PID stage.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   IR_vld     in   single-cycle pulse, a new set of IR readings is stable
//   clr_accum  out  clears the datapath accumulator
//   en_accum   out  enables one datapath accumulate
//   sub        out  datapath subtracts the selected term
//   sel        out  datapath mux select
//   busy       out  a sequence is in progress
//   err_vld    out  single-cycle pulse, datapath error holds its final value
//
// Build option:
//   ERR_CTRL_RETRIG_EN  when defined, IR_vld while busy aborts the running
//                       sequence and restarts at CLR; otherwise one request
//                       is queued in a single-deep pending flag.
module err_compute_ctrl
  import err_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IR_vld,
  output logic             clr_accum,
  output logic             en_accum,
  output logic             sub,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             err_vld
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_CLR    = CLR;
  localparam logic [2:0] ST_SETTLE = SETTLE;
  localparam logic [2:0] ST_ACCUM  = ACCUM;
  localparam logic [2:0] ST_DONE   = DONE;

  // The settle counter counts down to zero, so it is loaded with one less
  // than the number of settle cycles.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE_CYC > 0) ? SETTLE_W'(SETTLE_CYC - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_TERM = SEL_W'(NUM_TERMS - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [SEL_W-1:0]    term_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

`ifndef ERR_CTRL_RETRIG_EN
  logic pending;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (IR_vld) state_nxt = ST_CLR;
      ST_CLR:    state_nxt = (SETTLE_CYC > 0) ? ST_SETTLE : ST_ACCUM;
      ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_ACCUM;
      ST_ACCUM:  if (term_cnt == LAST_TERM) state_nxt = ST_DONE;
`ifdef ERR_CTRL_RETRIG_EN
      ST_DONE:   state_nxt = ST_IDLE;
`else
      // A request seen in DONE itself is treated the same as a queued one.
      ST_DONE:   state_nxt = (pending || IR_vld) ? ST_CLR : ST_IDLE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
`ifdef ERR_CTRL_RETRIG_EN
    // Any new request while busy abandons the current sum and starts over.
    if (IR_vld && (state != ST_IDLE)) state_nxt = ST_CLR;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      term_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_CLR)
        settle_cnt <= SETTLE_LOAD;
      else if ((state == ST_SETTLE) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - 1'b1;

      // Natural 3-bit wrap brings the counter back to 0 after the last term;
      // the explicit clear covers a sequence aborted mid-ACCUM.
      if (state_nxt == ST_CLR)
        term_cnt <= '0;
      else if (state == ST_ACCUM)
        term_cnt <= term_cnt + 1'b1;
    end
  end

`ifndef ERR_CTRL_RETRIG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= 1'b0;
    else if (state_nxt == ST_CLR)
      pending <= 1'b0;
    else if (IR_vld && (state != ST_IDLE))
      pending <= 1'b1;
  end
`endif

  always_comb begin
    clr_accum = (state == ST_CLR);
    en_accum  = (state == ST_ACCUM);
    sel       = en_accum ? term_cnt : '0;
    sub       = en_accum & term_cnt[0];
    busy      = (state != ST_IDLE);
    err_vld   = (state == ST_DONE);
  end

endmodule

// File: tb/tb_err_compute_ctrl.sv
// tb/tb_err_compute_ctrl.sv - self-checking bench for err_compute_ctrl
module tb_err_compute_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vld0, vld3;
  logic       clr0, en0, sub0, busy0, err0;
  logic [2:0] sel0;
  logic       clr3, en3, sub3, busy3, err3;
  logic [2:0] sel3;

  err_compute_ctrl #(.SETTLE_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .IR_vld(vld0),
    .clr_accum(clr0), .en_accum(en0), .sub(sub0), .sel(sel0),
    .busy(busy0), .err_vld(err0)
  );

  err_compute_ctrl #(.SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .IR_vld(vld3),
    .clr_accum(clr3), .en_accum(en3), .sub(sub3), .sel(sel3),
    .busy(busy3), .err_vld(err3)
  );

  int errors = 0;
  int checks = 0;

  // Datapath model: mux of weighted IR terms plus 16-bit accumulator.
  logic [11:0] ir_r [4];
  logic [11:0] ir_l [4];
  logic [15:0] acc;

  function automatic logic [15:0] term(input logic [2:0] s);
    logic [15:0] v;
    v = s[0] ? {4'h0, ir_l[s[2:1]]} : {4'h0, ir_r[s[2:1]]};
    return v << s[2:1];
  endfunction

  always @(posedge clk) begin
    if (clr0)     acc <= 16'h0000;
    else if (en0) acc <= sub0 ? acc - term(sel0) : acc + term(sel0);
  end

  function automatic logic [7:0] pack(input bit c, input bit e, input bit s,
                                      input bit [2:0] sl, input bit b, input bit v);
    return {c, e, s, sl, b, v};
  endfunction

  // Expected outputs for one sequence started by IR_vld in cycle 0.
  function automatic logic [7:0] exp_out(input int s, input int c);
    if (c == 1)                     return pack(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    if (c >= 2 && c < 2 + s)        return pack(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    if (c >= 2 + s && c < 10 + s)   return pack(1'b0, 1'b1, 1'((c - 2 - s) % 2),
                                                3'(c - 2 - s), 1'b1, 1'b0);
    if (c == 10 + s)                return pack(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    return 8'h00;
  endfunction

  typedef struct {
    logic       vld;
    logic [7:0] e0;
    logic [7:0] e3;
  } vec_t;

  localparam int NCYC = 16;
  vec_t tbl [NCYC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input bit swap);
    for (int i = 0; i < 4; i++) begin
      ir_r[i] = swap ? 12'h000 : 12'h100;
      ir_l[i] = swap ? 12'h100 : 12'h000;
    end
  endtask

  task automatic apply_table(input logic [15:0] exp_err);
    for (int c = 0; c < NCYC; c++) begin
      vld0 = tbl[c].vld;
      vld3 = tbl[c].vld;
      check($sformatf("dut0 cycle %0d", c),
            {8'h00, clr0, en0, sub0, sel0, busy0, err0}, {8'h00, tbl[c].e0});
      check($sformatf("dut3 cycle %0d", c),
            {8'h00, clr3, en3, sub3, sel3, busy3, err3}, {8'h00, tbl[c].e3});
      if (tbl[c].e0[0])
        check($sformatf("error value cycle %0d", c), acc, exp_err);
      tick();
    end
    vld0 = 1'b0;
    vld3 = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      tbl[c].vld = (c == 0);
      tbl[c].e0  = exp_out(0, c);
      tbl[c].e3  = exp_out(3, c);
    end

    rst_n = 1'b0;
    vld0  = 1'b0;
    vld3  = 1'b0;
    set_ir(1'b0);
    repeat (2) tick();
    check("reset outputs dut0", {8'h00, clr0, en0, sub0, sel0, busy0, err0}, 16'h0000);
    check("reset outputs dut3", {8'h00, clr3, en3, sub3, sel3, busy3, err3}, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Basic / settle sequences with end-to-end error values.
    set_ir(1'b0);
    apply_table(16'h0F00);
    set_ir(1'b1);
    apply_table(16'hF100);
    repeat (2) tick();

    // Overlapping requests on the SETTLE_CYC=0 instance.
    for (int c = 0; c < 26; c++) begin
      bit exp_clr, exp_err, exp_busy;
`ifdef ERR_CTRL_RETRIG_EN
      vld0     = (c == 0 || c == 5);
      exp_clr  = (c == 1 || c == 6);
      exp_err  = (c == 15);
      exp_busy = (c >= 1 && c <= 15);
`else
      vld0     = (c == 0 || c == 4 || c == 6);
      exp_clr  = (c == 1 || c == 11);
      exp_err  = (c == 10 || c == 20);
      exp_busy = (c >= 1 && c <= 20);
`endif
      check($sformatf("overlap clr_accum cycle %0d", c), {15'h0, clr0}, {15'h0, exp_clr});
      check($sformatf("overlap err_vld cycle %0d", c), {15'h0, err0}, {15'h0, exp_err});
      check($sformatf("overlap busy cycle %0d", c), {15'h0, busy0}, {15'h0, exp_busy});
      tick();
    end
    vld0 = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a sequence.
    set_ir(1'b0);
    vld0 = 1'b1;
    vld3 = 1'b1;
    tick();
    vld0 = 1'b0;
    vld3 = 1'b0;
    repeat (4) tick();
    check("mid-sequence en_accum before reset", {15'h0, en0}, 16'h0001);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset outputs dut0", {8'h00, clr0, en0, sub0, sel0, busy0, err0}, 16'h0000);
    check("async reset outputs dut3", {8'h00, clr3, en3, sub3, sel3, busy3, err3}, 16'h0000);
    tick();
    rst_n = 1'b1;
    apply_table(16'h0F00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
